// File: rtl/sram_dual_port.sv
// sram_dual_port: simple-dual-port block RAM with per-lane write enables,
// selectable read-during-write behaviour, an optional output register and a
// clear engine that sweeps the whole array after reset or on request.
module sram_dual_port #(
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512,
    parameter int DATA_WIDTH = 18,
    parameter int LANE_WIDTH = 9,
    parameter int READ_MODE  = 0,
    parameter int OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    localparam int LANES = DATA_WIDTH / LANE_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    output logic                  o_busy,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_AddrWrite,
    input  logic [LANES-1:0]      i_WriteEn,
    input  logic [DATA_WIDTH-1:0] i_Data,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_AddrRead,
    output logic [DATA_WIDTH-1:0] o_Data,
    output logic                  o_valid
);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   sweepAddr_q;
    logic [ADDR_WIDTH-1:0]   sweepAddr_d;

    // The array deliberately has no reset so it maps onto block RAM.
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    writeAccept;
    logic                    readAccept;
    logic                    writeInRange;
    logic                    readInRange;
    logic [DATA_WIDTH-1:0]   rdData_d;
    logic [DATA_WIDTH-1:0]   rdData_q;
    logic                    rdValid_q;

    assign o_busy       = (state_q == CLEAR);
    assign writeAccept  = (state_q == IDLE) && i_write;
    assign readAccept   = (state_q == IDLE) && i_read;
    assign writeInRange = ({1'b0, i_AddrWrite} < DEPTH_EXT);
    assign readInRange  = ({1'b0, i_AddrRead} < DEPTH_EXT);

    // State register and sweep counter; reset restarts the sweep from address 0.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= CLEAR;
            sweepAddr_q <= '0;
        end else begin
            state_q     <= state_d;
            sweepAddr_q <= sweepAddr_d;
        end
    end

    // Next-state logic: sweep every address once, then wait for a clear request.
    always_comb begin
        state_d     = state_q;
        sweepAddr_d = sweepAddr_q;
        case (state_q)
            CLEAR: begin
                if (sweepAddr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end else begin
                    sweepAddr_d = sweepAddr_q + 1'b1;
                end
            end
            IDLE: begin
                if (i_clear) begin
                    state_d     = CLEAR;
                    sweepAddr_d = '0;
                end
            end
            default: begin
                state_d     = CLEAR;
                sweepAddr_d = '0;
            end
        endcase
    end

    // Array write port: the sweep owns the port while clearing, otherwise lane-masked user writes.
    always_ff @(posedge i_clk) begin
        if (state_q == CLEAR) begin
            mem[sweepAddr_q] <= CLEAR_VALUE;
        end else if (writeAccept && writeInRange) begin
            for (int k = 0; k < LANES; k++) begin
                if (i_WriteEn[k]) begin
                    mem[i_AddrWrite][k*LANE_WIDTH +: LANE_WIDTH] <= i_Data[k*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // Read word selection: out-of-range reads give zero, write-through mode forwards colliding lanes.
    always_comb begin
        rdData_d = '0;
        if (readInRange) begin
            rdData_d = mem[i_AddrRead];
            if ((READ_MODE == 1) && writeAccept && (i_AddrWrite == i_AddrRead)) begin
                for (int k = 0; k < LANES; k++) begin
                    if (i_WriteEn[k]) begin
                        rdData_d[k*LANE_WIDTH +: LANE_WIDTH] = i_Data[k*LANE_WIDTH +: LANE_WIDTH];
                    end
                end
            end
        end
    end

    // First read stage: data only updates on an accepted read so the output holds otherwise.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rdData_q  <= '0;
            rdValid_q <= 1'b0;
        end else begin
            rdValid_q <= readAccept;
            if (readAccept) begin
                rdData_q <= rdData_d;
            end
        end
    end

    if (OUT_REG != 0) begin : gOutReg
        logic [DATA_WIDTH-1:0] pipeData_q;
        logic                  pipeValid_q;

        // Optional output stage adds one cycle of latency at full throughput.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                pipeData_q  <= '0;
                pipeValid_q <= 1'b0;
            end else begin
                pipeValid_q <= rdValid_q;
                if (rdValid_q) begin
                    pipeData_q <= rdData_q;
                end
            end
        end

        assign o_Data  = pipeData_q;
        assign o_valid = pipeValid_q;
    end else begin : gNoOutReg
        assign o_Data  = rdData_q;
        assign o_valid = rdValid_q;
    end

endmodule

// File: tb/tb_sram_dual_port.sv
// tb_sram_dual_port: drives two RAM instances (read-first/unregistered with
// full depth, write-through/registered with a shortened depth) from one
// stimulus stream and checks both against a behavioural model every cycle.
module tb_sram_dual_port;

    localparam int AW     = 9;
    localparam int DW     = 18;
    localparam int LW     = 9;
    localparam int LANES  = 2;
    localparam int DEPTH0 = 512;
    localparam int DEPTH1 = 400;
    localparam logic [DW-1:0] CV = 18'h0ABCD;

    logic           i_clk = 1'b0;
    logic           i_reset = 1'b1;
    logic           i_clear = 1'b0;
    logic           i_write = 1'b0;
    logic [AW-1:0]  i_AddrWrite = '0;
    logic [LANES-1:0] i_WriteEn = '0;
    logic [DW-1:0]  i_Data = '0;
    logic           i_read = 1'b0;
    logic [AW-1:0]  i_AddrRead = '0;

    logic           busy0, valid0, busy1, valid1;
    logic [DW-1:0]  data0, data1;

    int testsRun    = 0;
    int testsFailed = 0;

    // Behavioural model state, one entry per instance.
    logic [DW-1:0]  modelMem [2][512];
    int             clearLeft [2];
    logic           expValid [2];
    logic [DW-1:0]  expData [2];
    logic           pipeV [2];
    logic [DW-1:0]  pipeD [2];

    always #5 i_clk = ~i_clk;

    sram_dual_port #(
        .ADDR_WIDTH(AW), .DEPTH(DEPTH0), .DATA_WIDTH(DW), .LANE_WIDTH(LW),
        .READ_MODE(0), .OUT_REG(0), .CLEAR_VALUE(CV)
    ) dut0 (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .o_busy(busy0),
        .i_write(i_write), .i_AddrWrite(i_AddrWrite), .i_WriteEn(i_WriteEn),
        .i_Data(i_Data), .i_read(i_read), .i_AddrRead(i_AddrRead),
        .o_Data(data0), .o_valid(valid0)
    );

    sram_dual_port #(
        .ADDR_WIDTH(AW), .DEPTH(DEPTH1), .DATA_WIDTH(DW), .LANE_WIDTH(LW),
        .READ_MODE(1), .OUT_REG(1), .CLEAR_VALUE(CV)
    ) dut1 (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .o_busy(busy1),
        .i_write(i_write), .i_AddrWrite(i_AddrWrite), .i_WriteEn(i_WriteEn),
        .i_Data(i_Data), .i_read(i_read), .i_AddrRead(i_AddrRead),
        .o_Data(data1), .o_valid(valid1)
    );

    function automatic int depthOf(input int d);
        return (d == 0) ? DEPTH0 : DEPTH1;
    endfunction

    // Word after a lane-masked write: enabled lanes from new data, rest from old.
    function automatic logic [DW-1:0] laneMerge(input logic [DW-1:0] old,
                                                input logic [DW-1:0] data,
                                                input logic [LANES-1:0] en);
        logic [DW-1:0] mask;
        mask = {{LW{en[1]}}, {LW{en[0]}}};
        return (old & ~mask) | (data & mask);
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    // One model step per clock edge (or on reset assertion).
    task automatic modelStep();
        logic busy, rdAcc, wrAcc;
        logic [DW-1:0] r;
        for (int d = 0; d < 2; d++) begin
            if (i_reset) begin
                for (int a = 0; a < 512; a++) modelMem[d][a] = CV;
                clearLeft[d] = depthOf(d);
                expValid[d]  = 1'b0;
                expData[d]   = '0;
                pipeV[d]     = 1'b0;
                pipeD[d]     = '0;
            end else begin
                busy  = (clearLeft[d] > 0);
                rdAcc = !busy && i_read;
                wrAcc = !busy && i_write;
                r = '0;
                if (rdAcc && (int'(i_AddrRead) < depthOf(d))) begin
                    r = modelMem[d][i_AddrRead];
                    if (d == 1 && wrAcc && i_AddrWrite == i_AddrRead)
                        r = laneMerge(r, i_Data, i_WriteEn);
                end
                if (wrAcc && (int'(i_AddrWrite) < depthOf(d)))
                    modelMem[d][i_AddrWrite] = laneMerge(modelMem[d][i_AddrWrite], i_Data, i_WriteEn);
                if (busy) begin
                    clearLeft[d]--;
                end else if (i_clear) begin
                    clearLeft[d] = depthOf(d);
                    for (int a = 0; a < 512; a++) modelMem[d][a] = CV;
                end
                if (d == 0) begin
                    expValid[d] = rdAcc;
                    if (rdAcc) expData[d] = r;
                end else begin
                    expValid[d] = pipeV[d];
                    if (pipeV[d]) expData[d] = pipeD[d];
                    pipeV[d] = rdAcc;
                    if (rdAcc) pipeD[d] = r;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge i_clk or posedge i_reset);
            modelStep();
        end
    end

    // Every cycle, compare both instances against the model shortly after the edge.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            checkOutput("busy0", DW'(busy0), DW'(clearLeft[0] > 0));
            checkOutput("valid0", DW'(valid0), DW'(expValid[0]));
            checkOutput("data0", data0, expData[0]);
            checkOutput("busy1", DW'(busy1), DW'(clearLeft[1] > 0));
            checkOutput("valid1", DW'(valid1), DW'(expValid[1]));
            checkOutput("data1", data1, expData[1]);
        end
    end

    // Drive one edge worth of inputs; returns just after that edge.
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] wa,
                                 input logic [LANES-1:0] we, input logic [DW-1:0] wd,
                                 input logic rd, input logic [AW-1:0] ra, input logic clr);
        @(negedge i_clk);
        i_write     = wr;
        i_AddrWrite = wa;
        i_WriteEn   = we;
        i_Data      = wd;
        i_read      = rd;
        i_AddrRead  = ra;
        i_clear     = clr;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idleStep();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic readStep(input logic [AW-1:0] ra);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, ra, 1'b0);
    endtask

    task automatic writeStep(input logic [AW-1:0] wa, input logic [LANES-1:0] we,
                             input logic [DW-1:0] wd);
        applyStimulus(1'b1, wa, we, wd, 1'b0, '0, 1'b0);
    endtask

    // Count edges until each instance drops busy, bounded, and compare to expectations.
    task automatic waitIdle(input string name, input int exp0, input int exp1);
        int e0, e1;
        e0 = 0;
        e1 = 0;
        i_write = 1'b0;
        i_read  = 1'b0;
        i_clear = 1'b0;
        for (int i = 1; i <= 700; i++) begin
            @(posedge i_clk);
            #1;
            if (!busy0 && e0 == 0) e0 = i;
            if (!busy1 && e1 == 0) e1 = i;
            if (e0 != 0 && e1 != 0) break;
        end
        checkOutput({name, "_edges0"}, DW'(e0), DW'(exp0));
        checkOutput({name, "_edges1"}, DW'(e1), DW'(exp1));
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_busy0"}, DW'(busy0), DW'(1));
        checkOutput({name, "_valid0"}, DW'(valid0), DW'(0));
        checkOutput({name, "_data0"}, data0, '0);
        checkOutput({name, "_busy1"}, DW'(busy1), DW'(1));
        checkOutput({name, "_valid1"}, DW'(valid1), DW'(0));
        checkOutput({name, "_data1"}, data1, '0);
    endtask

    initial begin
        logic wr, rd, clr;
        logic [AW-1:0] wa, ra;

        $display("[TB] start");
        repeat (3) @(posedge i_clk);
        #1;
        checkResetOutputs("reset");
        @(negedge i_clk);
        i_reset = 1'b0;
        waitIdle("powerup", 512, 400);

        // Freshly cleared words
        readStep(9'd0);
        checkOutput("clr_rd0", data0, CV);
        checkOutput("clr_rd0_valid", DW'(valid0), DW'(1));
        readStep(9'd255);
        checkOutput("clr_rd255", data0, CV);
        readStep(9'd511);
        checkOutput("clr_rd511", data0, CV);
        checkOutput("clr_rd511_valid", DW'(valid0), DW'(1));

        // Full write then lane write
        writeStep(9'd3, 2'b11, 18'h1A5A5);
        readStep(9'd3);
        checkOutput("wr_full0", data0, 18'h1A5A5);
        idleStep();
        checkOutput("wr_full1", data1, 18'h1A5A5);
        checkOutput("wr_full1_valid", DW'(valid1), DW'(1));
        writeStep(9'd3, 2'b01, 18'h000FF);
        readStep(9'd3);
        checkOutput("wr_lane0", data0, 18'h1A4FF);

        // Collision
        writeStep(9'd7, 2'b11, 18'h00001);
        applyStimulus(1'b1, 9'd7, 2'b11, 18'h12345, 1'b1, 9'd7, 1'b0);
        checkOutput("coll_readfirst", data0, 18'h00001);
        idleStep();
        checkOutput("coll_writethru", data1, 18'h12345);

        // Out-of-range read on the shortened instance
        readStep(9'd450);
        checkOutput("oor_dut0", data0, CV);
        idleStep();
        checkOutput("oor_valid1", DW'(valid1), DW'(1));
        checkOutput("oor_data1", data1, '0);

        // Preload and back-to-back reads through the output register
        for (int k = 0; k < 4; k++) writeStep(AW'(k), 2'b11, DW'(10 + k));
        for (int k = 0; k < 6; k++) begin
            if (k < 4) readStep(AW'(k));
            else idleStep();
            if (k < 4) checkOutput("b2b_data0", data0, DW'(10 + k));
            checkOutput("b2b_valid1", DW'(valid1), DW'(k >= 1 && k <= 4));
            if (k >= 1 && k <= 4) checkOutput("b2b_data1", data1, DW'(10 + k - 1));
        end

        // Clear request with same-edge write and read, then accesses while busy
        applyStimulus(1'b1, 9'd9, 2'b11, 18'h3FFFF, 1'b1, 9'd3, 1'b1);
        checkOutput("clrEdge_read0", data0, DW'(13));
        checkOutput("clrEdge_valid0", DW'(valid0), DW'(1));
        checkOutput("clrEdge_busy0", DW'(busy0), DW'(1));
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, AW'($urandom_range(0, 511)), 2'b11, DW'($urandom),
                          1'b1, AW'($urandom_range(0, 511)), 1'b0);
            checkOutput("busy_novalid0", DW'(valid0), DW'(0));
        end
        waitIdle("clear", 492, 380);
        for (int a = 0; a < 512; a++) begin
            readStep(AW'(a));
            checkOutput("postclear0", data0, CV);
        end

        // Reset in the middle of a sweep
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        repeat (200) idleStep();
        #2;
        i_reset = 1'b1;
        #1;
        checkResetOutputs("midsweep");
        @(negedge i_clk);
        i_reset = 1'b0;
        waitIdle("midsweep", 512, 400);

        // Reset while reads are in flight
        readStep(9'd5);
        readStep(9'd6);
        checkOutput("inflight_valid0", DW'(valid0), DW'(1));
        checkOutput("inflight_valid1", DW'(valid1), DW'(1));
        #2;
        i_reset = 1'b1;
        #1;
        checkResetOutputs("inflight");
        @(negedge i_clk);
        i_reset = 1'b0;
        waitIdle("inflight", 512, 400);

        // Randomized traffic with frequent collisions and rare clears
        for (int n = 0; n < 2500; n++) begin
            wr  = 1'($urandom_range(0, 1));
            rd  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 299) == 0);
            wa  = AW'($urandom_range(0, 511));
            ra  = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 511));
            applyStimulus(wr, wa, LANES'($urandom_range(0, 3)), DW'($urandom), rd, ra, clr);
        end
        idleStep();
        idleStep();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sram_dual_port.md
# sram_dual_port

Parametrised simple-dual-port block RAM with independent read and write ports, per-lane write enables, a selectable read-during-write mode, an optional output pipeline register, and a built-in clear engine. The clear engine fills the whole array with a constant after reset or on request. It is the next-generation storage primitive for line buffers, sprite/tile memories and FIFOs in the design, and it maps onto FPGA block RAM: the array itself has no reset.

## Interface
- ADDR_WIDTH, 9, address width of both ports
- DEPTH, 512, number of words; DEPTH <= 2^ADDR_WIDTH
- DATA_WIDTH, 18, word width
- LANE_WIDTH, 9, lane width; DATA_WIDTH must be a multiple of it; LANES = DATA_WIDTH/LANE_WIDTH
- READ_MODE, 0, 0 = read-first (old data on collision), 1 = write-through (new data on collision)
- OUT_REG, 0, 1 adds one output pipeline stage
- CLEAR_VALUE, 0, DATA_WIDTH-bit value written by the clear engine

Ports:
- i_clk  in  1  single clock, all logic on its rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_clear  in  1  one-cycle request to start a clear sweep
- o_busy  out  1  clear sweep in progress; user accesses are ignored while high
- i_write  in  1  write strobe
- i_AddrWrite  in  ADDR_WIDTH  write address
- i_WriteEn  in  LANES  per-lane write enable; lane k is bits [k*LANE_WIDTH +: LANE_WIDTH]
- i_Data  in  DATA_WIDTH  write data
- i_read  in  1  read strobe
- i_AddrRead  in  ADDR_WIDTH  read address
- o_Data  out  DATA_WIDTH  read data
- o_valid  out  1  o_Data carries the result of an accepted read this cycle

## Operation
- FSM has two states: CLEAR and IDLE. i_reset forces CLEAR and sets the sweep counter to 0, asynchronously.
- CLEAR state:
  - each edge writes CLEAR_VALUE to address counter, then increments the counter.
  - after address DEPTH-1 is written, the FSM moves to IDLE.
  - o_busy = 1 for the whole state.
  - i_write, i_read and i_clear are ignored; no o_valid is produced.
- IDLE state:
  - i_clear = 1 sets the counter to 0 and moves to CLEAR; user strobes sampled on that same edge are still accepted.
- Write: accepted when i_write = 1 and the FSM is in IDLE. Only lanes with i_WriteEn = 1 are updated. An all-zero i_WriteEn leaves the word unchanged.
- Read: accepted when i_read = 1 and the FSM is in IDLE.
- Read and write are fully independent. Both may be accepted on the same edge, to any addresses.
- Collision (same address on both ports, same edge):
  - READ_MODE 0: returns the word before the write.
  - READ_MODE 1: returns the merged word, i.e. enabled lanes from i_Data and the other lanes from old contents.
- Out-of-range address (>= DEPTH):
  - write: ignored, array unchanged.
  - read: accepted, returns all zeros with o_valid = 1.
- o_Data holds its last value when no read completes. It is not cleared by the clear engine.

## Timing
- Reset values: o_Data = 0, o_valid = 0, o_busy = 1, FSM = CLEAR, counter = 0. The pipeline stage, when present, also resets to 0 / invalid.
- Clear duration:
  - o_busy stays high through reset and for exactly DEPTH rising edges after i_reset deasserts (edges 1..DEPTH write addresses 0..DEPTH-1).
  - o_busy falls after edge DEPTH.
  - The first user access is accepted on edge DEPTH+1.
- i_clear accepted on edge n: o_busy rises after edge n and falls after edge n+DEPTH.
- Read latency, from the accepting edge to o_Data/o_valid: 1 cycle with OUT_REG = 0, 2 cycles with OUT_REG = 1.
- o_valid is a single-cycle pulse per accepted read. Back-to-back reads give continuous o_valid at full throughput.
- A write on edge n is visible to a non-colliding read accepted on edge n+1.
- i_reset asserted mid-sweep: the sweep restarts from address 0 after release. In-flight reads are discarded and o_valid drops immediately.
- A read accepted on the edge where IDLE moves to CLEAR still completes normally.

## Test plan
- Reset release with DEPTH = 512: o_busy high for 512 edges. Then read addresses 0, 255 and 511 -> each returns CLEAR_VALUE with o_valid one cycle later (OUT_REG = 0).
- Write 0x1A5A5 to address 3, then read address 3 -> 0x1A5A5. Then write 0x0_0FF with i_WriteEn = 2'b01 and read -> 0x1A4FF (upper lane kept).
- Collision: write 0x12345 to address 7 (old value 0x00001) while reading address 7 -> READ_MODE 0 returns 0x00001; READ_MODE 1 returns 0x12345.
- OUT_REG = 1 with reads on 4 consecutive edges to addresses 0..3 (preloaded 10..13) -> o_valid high for 4 cycles starting 2 cycles later, data 10, 11, 12, 13 in order.
- Pulse i_clear in IDLE with i_write asserted on the same edge, then issue writes/reads during o_busy -> the same-edge write lands but is later overwritten. Busy-period accesses produce no o_valid. All words read CLEAR_VALUE afterwards.
- Assert i_reset at sweep address 200 -> o_valid = 0 and o_busy = 1 immediately. After release, o_busy lasts a full 512 edges.
